// File: rtl/rom_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rom_fetch_ctrl
// Brief    : Burst read initiator for bram_rd_port ROM wrappers. Issues
//            sequential addresses and caps in-flight requests. Forwards the
//            returned words in order, flags the last word of each burst,
//            and pulses done when the burst completes.
// Revision : 1.0 - initial release
// ============================================================================
module rom_fetch_ctrl #(
  parameter int W_DATA          = 13,
  parameter int W_ADDR          = 12,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [W_ADDR-1:0] cmd_base,
  input  logic [W_ADDR:0]   cmd_count,
  output logic              addr1_valid,
  input  logic              addr1_ready,
  output logic [W_ADDR-1:0] addr1_data,
  input  logic              data1_valid,
  output logic              data1_ready,
  input  logic [W_DATA-1:0] data1,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [W_DATA-1:0] dout_data,
  output logic              dout_last,
  output logic              done
);

  localparam int                c_OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_OW-1:0]   c_MAX_OUT = c_OW'(MAX_OUTSTANDING);
  localparam logic [c_OW-1:0]   c_OUT_ONE = c_OW'(1);
  localparam logic [W_ADDR:0]   c_CNT_ONE = (W_ADDR + 1)'(1);
  localparam logic [W_ADDR-1:0] c_ADR_ONE = W_ADDR'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [W_ADDR-1:0] r_addr;
  logic [W_ADDR:0]   r_count;
  logic [W_ADDR:0]   r_issue_cnt;
  logic [W_ADDR:0]   r_ret_cnt;
  logic [c_OW-1:0]   r_outstanding;

  logic w_has_out;
  logic w_is_last;
  logic w_addr_hs;
  logic w_data_hs;
  logic w_dout_hs;
  logic w_cmd_hs;

  // The data channel is only live while words are in flight, so a stray
  // data1_valid with nothing outstanding never reaches the downstream port.
  assign w_has_out  = (r_outstanding != '0);
  assign w_is_last  = (r_ret_cnt == (r_count - c_CNT_ONE));
  assign w_addr_hs  = addr1_valid && addr1_ready;
  assign w_data_hs  = data1_valid && data1_ready;
  assign w_dout_hs  = dout_valid && dout_ready;
  assign w_cmd_hs   = cmd_valid && cmd_ready;
  assign addr1_data = r_addr;
  assign dout_data  = data1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; every output is gated by state so an
  // asserted reset silences the block in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    addr1_valid = 1'b0;
    data1_ready = 1'b0;
    dout_valid  = 1'b0;
    dout_last   = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          w_state_nxt = (cmd_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Issue gating uses the registered outstanding count only; a return
        // in the same cycle frees a slot one cycle later.
        addr1_valid = (r_issue_cnt < r_count) && (r_outstanding < c_MAX_OUT);
        dout_valid  = data1_valid && w_has_out;
        data1_ready = dout_ready && w_has_out;
        dout_last   = dout_valid && w_is_last;
        if (dout_valid && dout_ready && w_is_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Burst bookkeeping: address pointer, issue/return counters, in-flight count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr        <= '0;
      r_count       <= '0;
      r_issue_cnt   <= '0;
      r_ret_cnt     <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_addr      <= cmd_base;
        r_count     <= cmd_count;
        r_issue_cnt <= '0;
        r_ret_cnt   <= '0;
      end
      if (w_addr_hs) begin
        r_addr      <= r_addr + c_ADR_ONE;
        r_issue_cnt <= r_issue_cnt + c_CNT_ONE;
      end
      if (w_dout_hs) begin
        r_ret_cnt <= r_ret_cnt + c_CNT_ONE;
      end
      case ({w_addr_hs, w_data_hs})
        2'b10:   r_outstanding <= r_outstanding + c_OUT_ONE;
        2'b01:   r_outstanding <= r_outstanding - c_OUT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule
`default_nettype wire
